// File: rtl/comp_pkg.sv
// Shared constants and types for the comparator SAR controller.
package comp_pkg;

  localparam int unsigned CMP_WIDTH = 8;

  // Comparator y_out encodings
  localparam logic [7:0] CMP_LT = 8'h01;
  localparam logic [7:0] CMP_GT = 8'h80;
  localparam logic [7:0] CMP_EQ = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/comp_sar_ctrl.sv
// Successive-approximation initiator for the 8-bit ALU comparator.
// Recovers the latched operand MSB first and flags illegal comparator responses.
module comp_sar_ctrl
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH  = CMP_WIDTH,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_val_in,
  output logic [WIDTH-1:0] a_reg_out,
  output logic [WIDTH-1:0] b_reg_out,
  output logic             cmp_en_n_out,
  input  logic [WIDTH-1:0] cmp_y_in,
  input  logic             cmp_zero_in,
  input  logic             cmp_carry_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] result_out,
  output logic             exact_out,
  output logic             error_out
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = 3;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_reg_q, a_reg_d;
  logic [WIDTH-1:0] b_reg_q, b_reg_d;
  logic             en_n_q, en_n_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exact_q, exact_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] bit_mask_c;
  logic             rsp_gt_c, rsp_lt_c, rsp_eq_c;
  logic             stop_c;

  // Trial bit and comparator response decode
  always_comb begin
    bit_mask_c = WIDTH'(1) << idx_q;
    rsp_gt_c   = (cmp_y_in == WIDTH'(CMP_GT)) && !cmp_zero_in && !cmp_carry_in;
    rsp_lt_c   = (cmp_y_in == WIDTH'(CMP_LT)) && !cmp_zero_in && !cmp_carry_in;
    rsp_eq_c   = (cmp_y_in == WIDTH'(CMP_EQ)) &&  cmp_zero_in && !cmp_carry_in;
  end

  // Next-state and next-output logic for the search FSM
  always_comb begin
    state_d  = state_q;
    a_reg_d  = a_reg_q;
    b_reg_d  = b_reg_q;
    en_n_d   = en_n_q;
    result_d = result_q;
    exact_d  = exact_q;
    error_d  = error_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    stop_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i_accept()) begin
          a_reg_d  = a_val_in;
          result_d = '0;
          exact_d  = 1'b0;
          error_d  = 1'b0;
          idx_d    = IDX_W'(WIDTH - 1);
          cnt_d    = '0;
          b_reg_d  = WIDTH'(1) << (WIDTH - 1);
          en_n_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = DRIVE;
        end
      end

      DRIVE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      EVAL: begin
        if (rsp_gt_c) begin
          result_d = result_q | bit_mask_c;
        end else if (rsp_lt_c) begin
          result_d = result_q;
        end else if (rsp_eq_c) begin
          result_d = b_reg_q;
          exact_d  = 1'b1;
          stop_c   = 1'b1;
        end else begin
          error_d  = 1'b1;
          stop_c   = 1'b1;
        end

        if (!stop_c && (idx_q != '0)) begin
          idx_d   = idx_q - IDX_W'(1);
          cnt_d   = '0;
          b_reg_d = result_d | (bit_mask_c >> 1);
          state_d = DRIVE;
        end else begin
          b_reg_d = '0;
          en_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Start is only honoured while idle
  function automatic logic start_i_accept();
    return start_in;
  endfunction

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      a_reg_q  <= '0;
      b_reg_q  <= '0;
      en_n_q   <= 1'b1;
      result_q <= '0;
      exact_q  <= 1'b0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_reg_q  <= a_reg_d;
      b_reg_q  <= b_reg_d;
      en_n_q   <= en_n_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      error_q  <= error_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

  assign a_reg_out    = a_reg_q;
  assign b_reg_out    = b_reg_q;
  assign cmp_en_n_out = en_n_q;
  assign result_out   = result_q;
  assign exact_out    = exact_q;
  assign error_out    = error_q;
  assign done_out     = done_q;
  assign busy_out     = busy_q;

endmodule

// File: tb/tb_comp_sar_ctrl.sv
// Bench for comp_sar_ctrl with a behavioural comparator and a result scoreboard.
module tb_comp_sar_ctrl;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SETTLE = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] a_reg, b_reg, cmp_y, result;
  logic             cmp_en_n, cmp_zero, cmp_carry;
  logic             busy, done, exact, error;
  bit               stub_mode;

  typedef struct {
    logic [7:0] res;
    logic       ex;
    logic       er;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] trials[$];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  comp_sar_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .start_in     (start),
    .a_val_in     (a_val),
    .a_reg_out    (a_reg),
    .b_reg_out    (b_reg),
    .cmp_en_n_out (cmp_en_n),
    .cmp_y_in     (cmp_y),
    .cmp_zero_in  (cmp_zero),
    .cmp_carry_in (cmp_carry),
    .busy_out     (busy),
    .done_out     (done),
    .result_out   (result),
    .exact_out    (exact),
    .error_out    (error)
  );

  // Behavioural 8-bit comparator, or a faulty stub returning 0x81
  always_comb begin
    cmp_y     = 8'h00;
    cmp_zero  = 1'b0;
    cmp_carry = 1'b0;
    if (stub_mode) begin
      cmp_y = 8'h81;
    end else if (!cmp_en_n) begin
      if (a_reg > b_reg)      cmp_y = 8'h80;
      else if (a_reg < b_reg) cmp_y = 8'h01;
      else begin
        cmp_y    = 8'h00;
        cmp_zero = 1'b1;
      end
    end
  end

  // Reference SAR search: final value, exact flag and number of compares
  function automatic exp_t model(input logic [7:0] a, input bit stub);
    exp_t       e;
    logic [7:0] res, trial;
    int         k;
    res = 8'h00;
    k   = 0;
    e.ex = 1'b0;
    e.er = 1'b0;
    if (stub) begin
      k    = 1;
      e.er = 1'b1;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        trial = res | (8'h01 << i);
        k++;
        if (trial == a) begin
          res  = trial;
          e.ex = 1'b1;
          break;
        end else if (a > trial) begin
          res = trial;
        end
      end
    end
    e.res = res;
    e.lat = k * (SETTLE + 1) + 1;
    return e;
  endfunction

  // Issue one start and wait (bounded) for done; records each new trial value
  task automatic do_search(input logic [7:0] a, output logic [7:0] r, output logic ex,
                           output logic er, output int lat, output bit timeout);
    trials.delete();
    a_val = a;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    a_val   = ~a;
    lat     = 1;
    timeout = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (!cmp_en_n && (trials.size() == 0 || trials[$] != b_reg)) trials.push_back(b_reg);
      if (done) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    r  = result;
    ex = exact;
    er = error;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_val = '0; stub_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_reg !== 8'h00)  begin failures++; $display("FAIL reset_a_reg got=%h exp=00", a_reg); end
    checks++; if (b_reg !== 8'h00)  begin failures++; $display("FAIL reset_b_reg got=%h exp=00", b_reg); end
    checks++; if (cmp_en_n !== 1'b1) begin failures++; $display("FAIL reset_en_n got=%b exp=1", cmp_en_n); end
    checks++; if ({busy, done, exact, error} !== 4'b0000)
      begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, exact, error}); end
    checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Full search with scoreboard check of result, flags, latency and end state
  task automatic test_search(input string name, input logic [7:0] a, input bit stub);
    logic [7:0] r;
    logic       ex, er;
    int         lat;
    bit         to;
    exp_t       e;
    stub_mode = stub;
    sb.push_back(model(a, stub));
    do_search(a, r, ex, er, lat, to);
    e = sb.pop_front();
    checks++; if (to) begin failures++; $display("FAIL %s done_timeout got=none exp=done", name); end
    checks++; if (r !== e.res) begin failures++; $display("FAIL %s result got=%h exp=%h", name, r, e.res); end
    checks++; if (ex !== e.ex) begin failures++; $display("FAIL %s exact got=%b exp=%b", name, ex, e.ex); end
    checks++; if (er !== e.er) begin failures++; $display("FAIL %s error got=%b exp=%b", name, er, e.er); end
    checks++; if (lat != e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, e.lat); end
    checks++; if (cmp_en_n !== 1'b1 || busy !== 1'b1)
      begin failures++; $display("FAIL %s done_state en_n/busy got=%b%b exp=11", name, cmp_en_n, busy); end
    checks++; if (a_reg !== a) begin failures++; $display("FAIL %s a_reg got=%h exp=%h", name, a_reg, a); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL %s after_done done/busy got=%b%b exp=00", name, done, busy); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (result !== e.res || exact !== e.ex || error !== e.er)
      begin failures++; $display("FAIL %s hold got=%h/%b/%b exp=%h/%b/%b", name, result, exact, error, e.res, e.ex, e.er); end
    stub_mode = 1'b0;
  endtask

  // 0x5A trial order must follow the MSB-first approximation
  task automatic test_trial_sequence();
    logic [7:0] exp_tr[$];
    exp_tr = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
    test_search("seq_5a", 8'h5A, 1'b0);
    checks++; if (trials.size() != exp_tr.size())
      begin failures++; $display("FAIL seq_5a trial_count got=%0d exp=%0d", trials.size(), exp_tr.size()); end
    for (int i = 0; i < exp_tr.size() && i < trials.size(); i++) begin
      checks++; if (trials[i] !== exp_tr[i])
        begin failures++; $display("FAIL seq_5a trial%0d got=%h exp=%h", i, trials[i], exp_tr[i]); end
    end
  endtask

  // Second start while busy is ignored; reset mid-search clears without a done pulse
  task automatic test_restart_and_reset();
    bit saw_done;
    a_val = 8'h5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    a_val = 8'h33;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (a_reg !== 8'h5A || busy !== 1'b1)
      begin failures++; $display("FAIL restart a_reg/busy got=%h/%b exp=5a/1", a_reg, busy); end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (a_reg !== 8'h00 || b_reg !== 8'h00 || result !== 8'h00)
      begin failures++; $display("FAIL midreset regs got=%h/%h/%h exp=00/00/00", a_reg, b_reg, result); end
    checks++; if (cmp_en_n !== 1'b1 || {busy, done, exact, error} !== 4'b0000)
      begin failures++; $display("FAIL midreset flags got=%b/%b exp=1/0000", cmp_en_n, {busy, done, exact, error}); end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin failures++; $display("FAIL midreset done_pulse got=1 exp=0"); end
    test_search("after_reset", 8'h33, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) test_search($sformatf("rand%0d", i), 8'($urandom_range(0, 255)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_trial_sequence();
    test_search("first_eq_80", 8'h80, 1'b0);
    test_search("zero_00", 8'h00, 1'b0);
    test_search("ones_ff", 8'hFF, 1'b0);
    test_search("stub_err", 8'h47, 1'b1);
    test_search("post_err_11", 8'h11, 1'b0);
    test_restart_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
